// File: rtl/mem_stage.sv
// Memory-access stage: word-addressed data memory, branch select and MEM/WB register.
// After every reset a small FSM zeroes the memory one word per cycle while Busy is high.
module mem_stage #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  WB_IN,
  input  logic [2:0]  MEM_IN,
  input  logic [31:0] BranchPC_IN,
  input  logic [31:0] AluResult_IN,
  input  logic [31:0] RD2_IN,
  input  logic        Zero_IN,
  input  logic [4:0]  WR_IN,
  output logic        PCSrc,
  output logic [31:0] BranchPC_OUT,
  output logic [1:0]  WB_OUT,
  output logic [31:0] ReadData_OUT,
  output logic [31:0] AluResult_OUT,
  output logic [4:0]  WR_OUT,
  output logic        Busy,
  output logic        AlignErr
);

  typedef enum logic {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mem_q [DEPTH];

  logic [1:0]      wb_q, wb_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     alu_q;
  logic [4:0]      wr_q;
  logic            align_err_q, align_err_d;

  logic            is_run;
  logic            branch, mem_read, mem_write;
  logic [AW-1:0]   idx;
  logic            aligned;
  logic            misalign;
  logic            do_store;
  logic            do_load;
  logic [31:0]     rd_word;

  assign branch    = MEM_IN[2];
  assign mem_read  = MEM_IN[1];
  assign mem_write = MEM_IN[0];

  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign idx      = AluResult_IN[AW+1:2];
  assign aligned  = (AluResult_IN[1:0] == 2'b00);
  assign is_run   = (state_q == StRun);
  assign misalign = is_run & (mem_read | mem_write) & ~aligned;
  assign do_store = is_run & mem_write & aligned;
  assign do_load  = is_run & mem_read & aligned;
  assign rd_word  = mem_q[idx];

  // State register for the clear FSM; reset restarts the clear at word 0.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: walk the counter through every word, then hand over to normal accesses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StClear;
    endcase
  end

  // Memory write port: clear writes in CLEAR, aligned stores in RUN, nothing under reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state_q == StClear) begin
        mem_q[cnt_q] <= '0;
      end else if (do_store) begin
        mem_q[idx] <= RD2_IN;
      end
    end
  end

  // Next values for the MEM/WB register; misaligned accesses squash the writeback.
  always_comb begin
    wb_d        = WB_IN;
    rdata_d     = '0;
    align_err_d = align_err_q;
    if (!is_run || misalign) begin
      wb_d = 2'b00;
    end
    if (do_load) begin
      rdata_d = rd_word;
    end
    if (misalign) begin
      align_err_d = 1'b1;
    end
  end

  // MEM/WB pipeline register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wb_q        <= '0;
      rdata_q     <= '0;
      alu_q       <= '0;
      wr_q        <= '0;
      align_err_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      rdata_q     <= rdata_d;
      alu_q       <= AluResult_IN;
      wr_q        <= WR_IN;
      align_err_q <= align_err_d;
    end
  end

  assign PCSrc         = branch & Zero_IN & is_run;
  assign BranchPC_OUT  = BranchPC_IN;
  assign Busy          = (state_q == StClear);
  assign WB_OUT        = wb_q;
  assign ReadData_OUT  = rdata_q;
  assign AluResult_OUT = alu_q;
  assign WR_OUT        = wr_q;
  assign AlignErr      = align_err_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It holds a word-addressed data memory, resolves the branch decision (PCSrc) for the fetch stage, and registers the results into the MEM/WB boundary. After every reset an internal FSM clears the data memory one word per cycle, with Busy asserted, before normal accesses are accepted.

## Interface
Parameters:
- DEPTH, 256: data memory size in 32-bit words; must be a power of two.
- AW, 8: word-address width; equals log2(DEPTH).

Ports:
- Clk  in  1  pipeline clock; all state updates on its rising edge.
- Rst  in  1  reset, synchronous, active-high.
- WB_IN  in  2  writeback controls: [1] RegWrite, [0] MemToReg.
- MEM_IN  in  3  memory controls: [2] Branch, [1] MemRead, [0] MemWrite.
- BranchPC_IN  in  32  branch target computed in EX.
- AluResult_IN  in  32  byte address for loads/stores; result for ALU ops.
- RD2_IN  in  32  store data.
- Zero_IN  in  1  ALU zero flag.
- WR_IN  in  5  destination register number.
- PCSrc  out  1  take-branch select to fetch (combinational).
- BranchPC_OUT  out  32  combinational pass-through of BranchPC_IN.
- WB_OUT  out  2  registered writeback controls to WB.
- ReadData_OUT  out  32  registered load data.
- AluResult_OUT  out  32  registered copy of AluResult_IN.
- WR_OUT  out  5  registered destination register.
- Busy  out  1  high while the clear FSM runs; the upstream stage holds while Busy is high.
- AlignErr  out  1  sticky misaligned-access flag.

## Operation
- FSM states are CLEAR and RUN.
  - Rst=1 forces CLEAR and sets the clear counter to 0.
  - In CLEAR, each cycle with Rst=0 writes 0 to mem[counter] and then increments the counter.
  - When the counter reaches DEPTH-1, the FSM moves to RUN.
- Busy = (state == CLEAR), including cycles in which Rst is asserted.
- The word index is AluResult_IN[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- An access is aligned when AluResult_IN[1:0] == 2'b00.
- Store (RUN, MemWrite=1, aligned): mem[index] ← RD2_IN at the clock edge.
- Load (RUN, MemRead=1, aligned): mem[index] is read combinationally and registered into ReadData_OUT.
- Misaligned MemRead or MemWrite in RUN:
  - The memory is not modified.
  - ReadData_OUT ← 0.
  - WB_OUT ← 2'b00, squashing the writeback.
  - AlignErr ← 1.
- When no load is issued, ReadData_OUT ← 0.
- PCSrc = Branch & Zero_IN & (state == RUN).
- Outside CLEAR, WB_OUT ← WB_IN unless squashed. In CLEAR, WB_OUT ← 0, so the stage emits bubbles.
- AluResult_OUT and WR_OUT are registered copies of AluResult_IN and WR_IN in every state.
- If MemRead and MemWrite are both 1, the store takes effect. ReadData_OUT returns the old word, because the read happens before the edge.

## Timing
- Reset values, on the edge where Rst=1:
  - WB_OUT=0, ReadData_OUT=0, AluResult_OUT=0, WR_OUT=0.
  - AlignErr=0, state=CLEAR, counter=0.
  - Busy=1 and PCSrc=0 in the following cycle.
- Memory contents are undefined until the clear completes.
- Clear length: after the first cycle with Rst=0, Busy stays high for exactly DEPTH cycles. RUN begins on the DEPTH-th edge, and Busy=0 from that cycle on.
- Rst reasserted mid-clear or mid-run restarts CLEAR at word 0. AlignErr is cleared.
- Register latency is 1 cycle: inputs present before edge N appear on WB_OUT, ReadData_OUT, AluResult_OUT and WR_OUT after edge N.
- Store-then-load to the same word on consecutive cycles: the load returns the new data, since the write lands at the edge between them.
- PCSrc and BranchPC_OUT have 0-cycle latency and are driven by the current inputs.
- AlignErr is sticky; only Rst clears it.

## Test plan
- Reset/clear (DEPTH=256): Rst high for 2 cycles, then low.
  - Busy stays high for exactly 256 cycles, then falls.
  - All registered outputs are 0.
  - A load from address 0x3FC then returns 0.
- Store/load round trip: store RD2=0xDEADBEEF at address 0x10, then a load from 0x10 on the next cycle with WB_IN=2'b11 and WR_IN=5'd8.
  - After the load edge: ReadData_OUT=0xDEADBEEF, WB_OUT=2'b11, WR_OUT=8.
- Address wrap: store 0x12345678 at 0x404 (DEPTH=256), then load 0x004.
  - The load returns 0x12345678.
- Misaligned: store at 0x11 with RD2=0xFFFFFFFF, then load 0x10.
  - AlignErr=1 and WB_OUT=0 on the store cycle's output.
  - The load from 0x10 returns the prior value.
  - AlignErr stays 1 until Rst.
- Branch: Branch=1 with Zero=1 gives PCSrc=1 and BranchPC_OUT=BranchPC_IN=5 in the same cycle.
  - Zero=0 gives PCSrc=0.
  - During CLEAR, PCSrc=0 regardless of inputs.
- Reset mid-operation: assert Rst at clear count 100.
  - Busy stays high for 256 cycles after Rst is released.
  - A store issued during CLEAR is ignored; a load of that word after the clear returns 0.
